// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM states, widths and default timing for the SPI master
package spi_pkg;

    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 3;   // bit index within one byte
    localparam int TIMER_W = 8;   // phase/setup/hold counts up to 256 cycles

    localparam int DEF_DIV_HALF = 4;
    localparam int DEF_CS_SETUP = 4;
    localparam int DEF_CS_HOLD  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake and SPI pin bundle for spi_master
// master modport: the spi_master block; slave modport: host logic plus SPI device.
interface spi_master_if;
    import spi_pkg::*;

    logic              start;
    logic [BYTE_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [BYTE_W-1:0] rx_data;
    logic              wake_sync;
    logic              spi_cs;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_wake;

    modport master (
        input  start, tx_data, spi_miso, spi_wake,
        output busy, done, rx_data, wake_sync, spi_cs, spi_clk, spi_mosi
    );

    modport slave (
        output start, tx_data, spi_miso, spi_wake,
        input  busy, done, rx_data, wake_sync, spi_cs, spi_clk, spi_mosi
    );

endinterface

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - down-counter timing setup, SCLK half-periods and hold
// Ports: clk, notreset (async, active low), load + load_value (count minus one),
// tick (one-cycle pulse on the last cycle of the loaded interval).
module spi_phase_timer
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               notreset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               tick
);

    logic [TIMER_W-1:0] cnt_q;
    logic               armed_q;

    always_ff @(posedge clk or negedge notreset) begin
        if (!notreset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= load_value;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - TIMER_W'(1);
            end
        end
    end

    // armed_q keeps tick from repeating while the counter sits at zero
    assign tick = armed_q && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI master, mode 0, active-high chip select
// Ports: clk, notreset (async, active low), bus (spi_master_if.master):
// start/tx_data in, busy/done/rx_data out, wake_sync out, spi_cs/spi_clk/spi_mosi
// out, spi_miso/spi_wake in. Optional: SPI_MASTER_AUTO_READ_EN (wake self-start).
module spi_master
    import spi_pkg::*;
#(
    parameter int DIV_HALF = DEF_DIV_HALF,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD
) (
    input  logic         clk,
    input  logic         notreset,
    spi_master_if.master bus
);

    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(CS_SETUP - 1);
    localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(DIV_HALF - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(BYTE_W - 1);

    spi_state_e         state_q, state_d;
    logic [BYTE_W-1:0]  shreg_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [BYTE_W-1:0]  rx_q;
    logic               done_q;
    logic               wake_meta_q, wake_sync_q;
    logic               tick, load;
    logic [TIMER_W-1:0] load_value;
    logic               self_start, accept, hold_end;

`ifdef SPI_MASTER_AUTO_READ_EN
    assign self_start = wake_sync_q && !bus.start;
`else
    assign self_start = 1'b0;
`endif

    // The done cycle is already IDLE but must not accept, so back-to-back
    // requests always see chip select drop between bytes.
    assign accept   = (state_q == ST_IDLE) && !done_q && (bus.start || self_start);
    assign hold_end = (state_q == ST_HOLD) && tick;

    spi_phase_timer u_timer (
        .clk        (clk),
        .notreset   (notreset),
        .load       (load),
        .load_value (load_value),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge notreset) begin
        if (!notreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_value = HALF_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SETUP;
                    load       = 1'b1;
                    load_value = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_LOW;
                    load    = 1'b1;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    state_d = ST_HIGH;
                    load    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = ST_HOLD;
                        load_value = HOLD_LOAD;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge notreset) begin
        if (!notreset) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            done_q      <= 1'b0;
            wake_meta_q <= 1'b0;
            wake_sync_q <= 1'b0;
        end else begin
            wake_meta_q <= bus.spi_wake;
            wake_sync_q <= wake_meta_q;
            done_q      <= hold_end;
            if (accept) begin
                shreg_q   <= bus.start ? bus.tx_data : '0;
                bit_cnt_q <= '0;
            end else if ((state_q == ST_HIGH) && tick) begin
                // MISO enters the LSB as MOSI leaves the MSB; after the eighth
                // shift the register holds exactly the received byte.
                shreg_q <= {shreg_q[BYTE_W-2:0], bus.spi_miso};
                if (bit_cnt_q != LAST_BIT) begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end
            if (hold_end) begin
                rx_q <= shreg_q;
            end
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.spi_cs    = (state_q != ST_IDLE);
    assign bus.spi_clk   = (state_q == ST_HIGH);
    assign bus.spi_mosi  = ((state_q == ST_SETUP) || (state_q == ST_LOW) ||
                            (state_q == ST_HIGH)) ? shreg_q[BYTE_W-1] : 1'b0;
    assign bus.done      = done_q;
    assign bus.rx_data   = rx_q;
    assign bus.wake_sync = wake_sync_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;
    import spi_pkg::*;

    localparam int DIV_HALF = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int LAT      = CS_SETUP + 16 * DIV_HALF + CS_HOLD + 1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sb;
        bit         loop;
        logic [7:0] exp_rx;
        int         restart_at;
    } vec_t;

    logic clk = 1'b0;
    logic notreset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[5];

    spi_master_if bus();

    spi_master #(
        .DIV_HALF (DIV_HALF),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk      (clk),
        .notreset (notreset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge, accepts on the next posedge, and plays an SPI slave
    // that shifts sb out MSB first (changing after each SCLK fall) or loops MOSI
    // back. Returns post cycles after done, at a negedge.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input bit loop,
                        input logic [7:0] exp_rx, input int restart_at, input int post,
                        input string tag);
        int         cyc = 0;
        int         lat = -1;
        int         rises = 0;
        int         falls = 0;
        int         dones = 0;
        int         gaps = 0;
        int         extra_busy = 0;
        logic [7:0] mo = 8'h00;
        logic [7:0] rx_at_done = 8'h00;
        logic       prev_clk = 1'b0;
        bus.start   = 1'b1;
        bus.tx_data = tx;
        @(negedge clk);
        bus.tx_data = ~tx;
        cyc = 1;
        check({tag, "_cs_rise"}, {31'd0, bus.spi_cs}, 32'd1);
        for (int g = 0; g < LAT + post + 40; g++) begin
            if (bus.spi_clk && !prev_clk && lat < 0) begin
                rises++;
                mo = {mo[6:0], bus.spi_mosi};
            end
            if (!bus.spi_clk && prev_clk) falls++;
            prev_clk = bus.spi_clk;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = cyc;
                    rx_at_done = bus.rx_data;
                end
            end else if (lat < 0 && !bus.busy) begin
                gaps++;
            end
            if (lat >= 0 && cyc > lat && bus.busy) extra_busy++;
            if (lat >= 0 && cyc >= lat + post) break;
            bus.start    = (cyc == restart_at);
            bus.spi_miso = loop ? bus.spi_mosi : ((falls < 8) ? sb[7 - falls] : 1'b0);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_sclk_pulses"}, rises, 8);
        check({tag, "_mosi_bits"}, {24'd0, mo}, {24'd0, tx});
        check({tag, "_rx_data"}, {24'd0, rx_at_done}, {24'd0, exp_rx});
        check({tag, "_busy_gaps"}, gaps, 0);
        if (post > 0) begin
            check({tag, "_done_pulses"}, dones, 1);
            check({tag, "_busy_after_done"}, extra_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rtx, rsb;
        bit         rloop;
        int         r3;
        logic       p;
        int         seen;

        tbl[0] = '{8'hA5, 8'h00, 1'b1, 8'hA5, -1};
        tbl[1] = '{8'h00, 8'h3C, 1'b0, 8'h3C, -1};
        tbl[2] = '{8'h5A, 8'hC3, 1'b0, 8'hC3, 10};
        tbl[3] = '{8'hFF, 8'h00, 1'b0, 8'h00, -1};
        tbl[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, -1};

        bus.start = 1'b0; bus.tx_data = 8'h00; bus.spi_miso = 1'b0; bus.spi_wake = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {27'd0, bus.busy, bus.done, bus.spi_cs, bus.spi_clk, bus.spi_mosi}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_wake_sync", {31'd0, bus.wake_sync}, 32'd0);

        notreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xfer(tbl[i].tx, tbl[i].sb, tbl[i].loop, tbl[i].exp_rx, tbl[i].restart_at, 6,
                 $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            rtx   = 8'($urandom);
            rsb   = 8'($urandom);
            rloop = 1'($urandom_range(0, 1));
            xfer(rtx, rsb, rloop, rloop ? rtx : rsb, -1, 3, $sformatf("rnd%0d", i));
        end

        // back-to-back: start on the done cycle is dropped, the next one is taken
        xfer(8'h3C, 8'h00, 1'b1, 8'h3C, -1, 0, "b2b_first");
        check("b2b_done_cycle_cs", {31'd0, bus.spi_cs}, 32'd0);
        bus.start = 1'b1; bus.tx_data = 8'h96;
        @(negedge clk);
        check("b2b_start_on_done_ignored", {30'd0, bus.busy, bus.spi_cs}, 32'd0);
        xfer(8'h96, 8'h00, 1'b1, 8'h96, -1, 4, "b2b_second");

        // asynchronous reset at the third SCLK high
        bus.start = 1'b1; bus.tx_data = 8'h3C;
        @(negedge clk);
        bus.start = 1'b0;
        r3 = 0; p = 1'b0;
        for (int i = 0; i < 200 && r3 < 3; i++) begin
            @(negedge clk);
            if (bus.spi_clk && !p) r3++;
            p = bus.spi_clk;
        end
        check("rst_mid_third_high", r3, 3);
        #2 notreset = 1'b0;
        #1;
        check("rst_mid_async_outputs", {28'd0, bus.busy, bus.done, bus.spi_cs, bus.spi_clk}, 32'd0);
        check("rst_mid_mosi_rx", {23'd0, bus.spi_mosi, bus.rx_data}, 32'd0);
        @(negedge clk); @(negedge clk);
        check("rst_mid_held", {29'd0, bus.busy, bus.spi_cs, bus.spi_clk}, 32'd0);
        notreset = 1'b1;
        xfer(8'h81, 8'h00, 1'b1, 8'h81, -1, 4, "post_rst_81");

        // wake input
        @(negedge clk);
        bus.spi_wake = 1'b1;
        @(negedge clk);
        check("wake_sync_lag1", {31'd0, bus.wake_sync}, 32'd0);
        @(negedge clk);
        check("wake_sync_lag2", {31'd0, bus.wake_sync}, 32'd1);
`ifdef SPI_MASTER_AUTO_READ_EN
        check("auto_cs_before", {31'd0, bus.spi_cs}, 32'd0);
        bus.spi_wake = 1'b0;
        @(negedge clk);
        check("auto_cs_3_cycles", {31'd0, bus.spi_cs}, 32'd1);
        seen = 0; p = 1'b0;
        for (int i = 0; i < LAT + 20 && seen == 0; i++) begin
            @(negedge clk);
            p = p | bus.spi_mosi;
            if (bus.done) seen = 1;
        end
        check("auto_done_seen", seen, 1);
        check("auto_mosi_zero", {31'd0, p}, 32'd0);
        repeat (5) @(negedge clk);
        check("auto_no_retrigger", {31'd0, bus.busy}, 32'd0);
`else
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.spi_cs || bus.busy) seen++;
        end
        check("wake_no_cs_activity", seen, 0);
        bus.spi_wake = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
